// File: rtl/fifo_write_logic.sv
// Write-domain controller of the router's async FIFO: write strobe/address, Gray write pointer,
// and full/almost-full/level/overflow flags derived from the synchronized Gray read pointer.
module fifo_write_logic #(
  parameter int PTR_SZ    = 2,
  parameter int AFULL_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   wq2_raddr,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel,
  output logic              wovf
);

  localparam logic [PTR_SZ:0] AFULL_LIM = AFULL_THR[PTR_SZ:0];

  typedef enum logic [1:0] {
    W_IDLE,
    W_ACTIVE,
    W_FULL
  } state_t;

  state_t          state, next_state;
  logic [PTR_SZ:0] wbin, wbin_next, gray_next, rbin, level_next;
  logic            full_next;

  function automatic logic [PTR_SZ:0] gray2bin(input logic [PTR_SZ:0] g);
    logic [PTR_SZ:0] b;
    b[PTR_SZ] = g[PTR_SZ];
    for (int i = PTR_SZ - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Full is held in the FSM state, so wfull is a registered flag with no extra flop.
  assign wfull    = (state == W_FULL);
  assign write_en = winc & ~wfull & rst;
  assign waddr    = wbin[PTR_SZ-1:0];

  always_comb begin
    wbin_next  = wbin + {{PTR_SZ{1'b0}}, write_en};
    gray_next  = wbin_next ^ (wbin_next >> 1);
    rbin       = gray2bin(wq2_raddr);
    level_next = wbin_next - rbin;
    full_next  = (gray_next == {~wq2_raddr[PTR_SZ:PTR_SZ-1], wq2_raddr[PTR_SZ-2:0]});
  end

  always_comb begin
    next_state = state;
    case (state)
      W_IDLE: begin
        if (full_next)     next_state = W_FULL;
        else if (write_en) next_state = W_ACTIVE;
      end
      W_ACTIVE: begin
        if (full_next)     next_state = W_FULL;
        else if (!winc)    next_state = W_IDLE;
      end
      W_FULL: begin
        if (!full_next)    next_state = W_IDLE;
      end
      default:             next_state = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= W_IDLE;
      wbin         <= '0;
      waddr_gray   <= '0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      wovf         <= 1'b0;
    end else begin
      state        <= next_state;
      wbin         <= wbin_next;
      waddr_gray   <= gray_next;
      walmost_full <= (level_next >= AFULL_LIM);
      wlevel       <= level_next;
      wovf         <= wovf | (winc & wfull);
    end
  end

endmodule

// File: tb/tb_fifo_write_logic.sv
// Randomized scoreboard bench for fifo_write_logic: an occupancy-count model predicts each cycle's
// outputs, and a monitor process pops and compares them after every clock edge.
module tb_fifo_write_logic;

  localparam int PTR_SZ    = 2;
  localparam int AFULL_THR = 3;
  localparam int DEPTH     = 1 << PTR_SZ;

  logic              clk = 1'b0;
  logic              rst;
  logic              winc;
  logic [PTR_SZ:0]   wq2_raddr;
  logic              write_en;
  logic [PTR_SZ-1:0] waddr;
  logic [PTR_SZ:0]   waddr_gray;
  logic              wfull;
  logic              walmost_full;
  logic [PTR_SZ:0]   wlevel;
  logic              wovf;

  typedef struct {
    bit we;
    int waddr;
    int gray;
    int level;
    bit full;
    bit afull;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
  int   checks = 0;
  int   errors = 0;
  int   m_wr = 0;
  int   m_rd = 0;
  bit   m_full = 0;
  bit   m_ovf = 0;
  logic we_s;

  fifo_write_logic #(.PTR_SZ(PTR_SZ), .AFULL_THR(AFULL_THR)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wq2_raddr(wq2_raddr),
    .write_en(write_en), .waddr(waddr), .waddr_gray(waddr_gray),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: r is the total number of words the reader has consumed so far.
  task automatic apply_stimulus(input bit w, input int r);
    exp_t e;
    int   lvl;
    @(negedge clk);
    winc      = w;
    wq2_raddr = 3'(gray_tab[r % 8]);
    e.we      = w && !m_full;
    if (e.we) m_wr++;
    m_rd    = r;
    lvl     = m_wr - m_rd;
    m_ovf   = m_ovf || (w && m_full);
    m_full  = (lvl == DEPTH);
    e.waddr = m_wr % DEPTH;
    e.gray  = gray_tab[m_wr % 8];
    e.level = lvl;
    e.full  = m_full;
    e.afull = (lvl >= AFULL_THR);
    e.ovf   = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    apply_stimulus(1'b0, m_rd);
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_write_en"}, 32'(write_en), 0);
    check_output({tag, "_waddr"}, 32'(waddr), 0);
    check_output({tag, "_waddr_gray"}, 32'(waddr_gray), 0);
    check_output({tag, "_wfull"}, 32'(wfull), 0);
    check_output({tag, "_walmost_full"}, 32'(walmost_full), 0);
    check_output({tag, "_wlevel"}, 32'(wlevel), 0);
    check_output({tag, "_wovf"}, 32'(wovf), 0);
  endtask

  // Monitor: write_en is sampled mid-low-phase, registered outputs just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3 we_s = write_en;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("write_en", 32'(we_s), 32'(e.we));
        check_output("waddr", 32'(waddr), 32'(e.waddr));
        check_output("waddr_gray", 32'(waddr_gray), 32'(e.gray));
        check_output("wlevel", 32'(wlevel), 32'(e.level));
        check_output("wfull", 32'(wfull), 32'(e.full));
        check_output("walmost_full", 32'(walmost_full), 32'(e.afull));
        check_output("wovf", 32'(wovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    rst       = 1'b0;
    winc      = 1'b0;
    wq2_raddr = '0;
    #2 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill from empty, then overflow attempt.
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 0);
    apply_stimulus(1'b1, 0);
    // One read frees a slot; then refill it.
    apply_stimulus(1'b0, 1);
    apply_stimulus(1'b1, 1);
    // Write while full coinciding with a read: refused now, accepted next cycle.
    apply_stimulus(1'b1, 2);
    apply_stimulus(1'b1, 2);
    drain();

    // Asynchronous reset mid-run while full at waddr=2.
    @(negedge clk);
    winc = 1'b1;
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk);
    winc      = 1'b0;
    wq2_raddr = '0;
    rst       = 1'b1;
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;

    // Free-running writer with a reader that keeps up: walks the full Gray cycle and wraps.
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, m_wr);

    // Random traffic with a slower reader so full and overflow recur.
    for (int i = 0; i < 400; i++) begin
      r = m_rd;
      if (m_rd < m_wr && $urandom_range(0, 2) == 0) r = m_rd + 1;
      apply_stimulus(1'($urandom_range(0, 3) != 0), r);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
